// File: rtl/truth_table_sweeper_if.sv
// Handshake and gate-facing signals of truth_table_sweeper.
// The master drives start and returns the gate output; the slave (sweeper) drives everything else.
interface truth_table_sweeper_if;
   logic       start;
   logic       out_in;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] mismatch;
   logic [7:0] fail_count;

   modport master (output start, out_in,
                   input  a, b, busy, done, pass, mismatch, fail_count);
   modport slave  (input  start, out_in,
                   output a, b, busy, done, pass, mismatch, fail_count);
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives a 2-input gate through 00,01,10,11, samples it after SETTLE cycles and reports mismatches.
// Optional saturating failed-sweep counter built only when SWEEP_FAIL_COUNT_EN is defined.
module truth_table_sweeper #(
   parameter logic [3:0] EXPECTED = 4'b0110,
   parameter int         SETTLE   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   truth_table_sweeper_if.slave sw
);
   localparam int         S_EFF    = (SETTLE < 1) ? 1 : SETTLE;
   localparam logic [7:0] CNT_LAST = 8'(S_EFF - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;

   logic [1:0] state;
   logic [1:0] vec;
   logic [1:0] ab;
   logic [7:0] cnt;
   logic       busy_r;
   logic       done_r;
   logic       pass_r;
   logic [3:0] mism_r;

   logic miss_now;
   logic last_sample;
   logic sweep_bad;

   assign miss_now    = sw.out_in ^ EXPECTED[vec];
   assign last_sample = (state == SAMPLE) && (vec == 2'd3);
   // final mask = earlier three bits plus the bit being sampled right now
   assign sweep_bad   = miss_now | (|mism_r[2:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         vec    <= 2'd0;
         ab     <= 2'b00;
         cnt    <= 8'd0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
         mism_r <= 4'b0000;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (sw.start) begin
                  state  <= DRIVE;
                  vec    <= 2'd0;
                  ab     <= 2'b00;
                  cnt    <= 8'd0;
                  busy_r <= 1'b1;
                  mism_r <= 4'b0000;
               end
            end
            DRIVE: begin
               cnt <= cnt + 8'd1;
               if (cnt == CNT_LAST) state <= SAMPLE;
            end
            SAMPLE: begin
               mism_r[vec] <= miss_now;
               if (vec != 2'd3) begin
                  vec   <= vec + 2'd1;
                  ab    <= vec + 2'd1;
                  cnt   <= 8'd0;
                  state <= DRIVE;
               end else begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  ab     <= 2'b00;
                  pass_r <= ~sweep_bad;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sw.a        = ab[1];
   assign sw.b        = ab[0];
   assign sw.busy     = busy_r;
   assign sw.done     = done_r;
   assign sw.pass     = pass_r;
   assign sw.mismatch = mism_r;

`ifdef SWEEP_FAIL_COUNT_EN
   logic [7:0] fcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fcnt <= 8'd0;
      else if (last_sample && sweep_bad && (fcnt != 8'hFF))
         fcnt <= fcnt + 8'd1;
   end

   assign sw.fail_count = fcnt;
`else
   assign sw.fail_count = 8'd0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed-plus-random bench for truth_table_sweeper: a gate model driven by a lookup table,
// with expected timing and masks computed from sample-edge arithmetic.
module tb_truth_table_sweeper;
`ifdef SWEEP_FAIL_COUNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif
   localparam logic [3:0] EXP0 = 4'b0110;
   localparam logic [3:0] EXP1 = 4'b1000;

   logic clk;
   logic reset;
   logic [3:0] gate0;
   logic [3:0] gate1;
   int n_pass;
   int n_total;
   bit exp_pass [2];
   int exp_fc [2];

   truth_table_sweeper_if if0 ();
   truth_table_sweeper_if if1 ();

   assign if0.out_in = gate0[{if0.a, if0.b}];
   assign if1.out_in = gate1[{if1.a, if1.b}];

   truth_table_sweeper #(.EXPECTED(EXP0), .SETTLE(2)) u0 (.clk(clk), .reset(reset), .sw(if0.slave));
   truth_table_sweeper #(.EXPECTED(EXP1), .SETTLE(0)) u1 (.clk(clk), .reset(reset), .sw(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // {ab, busy, done, pass, mismatch, fail_count}
   function automatic logic [16:0] st(input int i);
      if (i == 0)
         return {if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.mismatch, if0.fail_count};
      return {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.mismatch, if1.fail_count};
   endfunction

   function automatic logic [3:0] model(input logic [3:0] gate, input logic [3:0] expt);
      logic [3:0] m;
      m = 4'b0000;
      for (int k = 0; k < 4; k++)
         if (((gate >> k) & 4'd1) != ((expt >> k) & 4'd1)) m = m | (4'd1 << k);
      return m;
   endfunction

   task automatic set_start(input int i, input logic v);
      if (i == 0) if0.start = v;
      else        if1.start = v;
   endtask

   task automatic set_gate(input int i, input logic [3:0] g);
      if (i == 0) gate0 = g;
      else        gate1 = g;
   endtask

   task automatic chk_idle(input int i, input string tag, input logic done_exp);
      logic [16:0] s;
      s = st(i);
      chk({tag, ".ab"},   32'(s[16:15]), 32'd0);
      chk({tag, ".busy"}, 32'(s[14]), 32'd0);
      chk({tag, ".done"}, 32'(s[13]), 32'(done_exp));
      chk({tag, ".pass"}, 32'(s[12]), 32'(exp_pass[i]));
      chk({tag, ".fc"},   32'(s[7:0]), 32'(exp_fc[i]));
   endtask

   // One full sweep; returns in the done cycle. chained: start was already high in the done cycle.
   task automatic sweep(input int i, input logic [3:0] gate, input bit hold, input bit chained);
      int p;
      logic [3:0] m;
      logic [3:0] em;
      logic [16:0] s;
      p = (i == 0) ? 3 : 2;
      m = model(gate, (i == 0) ? EXP0 : EXP1);
      set_gate(i, gate);
      if (!chained) set_start(i, 1'b1);
      tick();
      if (!hold) set_start(i, 1'b0);
      for (int e = 0; e < 4 * p; e++) begin
         s = st(i);
         em = 4'b0000;
         for (int k = 0; k < 4; k++)
            if ((k + 1) * p <= e) em[k] = m[k];
         chk("run.ab",       32'(s[16:15]), 32'(e / p));
         chk("run.busy",     32'(s[14]), 32'd1);
         chk("run.done",     32'(s[13]), 32'd0);
         chk("run.pass",     32'(s[12]), 32'(exp_pass[i]));
         chk("run.mismatch", 32'(s[11:8]), 32'(em));
         chk("run.fc",       32'(s[7:0]), 32'(exp_fc[i]));
         tick();
      end
      exp_pass[i] = (m == 4'b0000);
      if (FC_EN && m != 4'b0000 && exp_fc[i] < 255) exp_fc[i]++;
      s = st(i);
      chk_idle(i, "end", 1'b1);
      chk("end.mismatch", 32'(s[11:8]), 32'(m));
   endtask

   initial begin
      logic [16:0] s;
      n_pass = 0;
      n_total = 0;
      exp_pass[0] = 1'b0; exp_pass[1] = 1'b0;
      exp_fc[0] = 0;      exp_fc[1] = 0;
      reset = 1'b1;
      if0.start = 1'b0;
      if1.start = 1'b0;
      gate0 = 4'b0110;
      gate1 = 4'b1000;
      #12;
      for (int i = 0; i < 2; i++) begin
         chk_idle(i, "rst", 1'b0);
         s = st(i);
         chk("rst.mismatch", 32'(s[11:8]), 32'd0);
      end
      tick();
      reset = 1'b0;
      tick();
      chk_idle(0, "idle", 1'b0);

      // correct XOR, then stuck-at-0
      sweep(0, 4'b0110, 1'b0, 1'b0);
      tick();
      chk_idle(0, "post", 1'b0);
      sweep(0, 4'b0000, 1'b0, 1'b0);
      tick();
      chk_idle(0, "post0", 1'b0);

      // start held through the sweep; the done-cycle start chains a second sweep
      sweep(0, 4'b0110, 1'b1, 1'b0);
      sweep(0, 4'b1111, 1'b0, 1'b1);
      tick();
      chk_idle(0, "chain", 1'b0);

      // reset after edge 7 of a sweep
      set_gate(0, 4'b0000);
      set_start(0, 1'b1);
      tick();
      set_start(0, 1'b0);
      repeat (7) tick();
      reset = 1'b1;
      #1;
      exp_pass[0] = 1'b0; exp_pass[1] = 1'b0;
      exp_fc[0] = 0;      exp_fc[1] = 0;
      chk_idle(0, "abort", 1'b0);
      s = st(0);
      chk("abort.mismatch", 32'(s[11:8]), 32'd0);
      tick();
      reset = 1'b0;
      repeat (4) begin
         tick();
         chk_idle(0, "abort.quiet", 1'b0);
      end
      sweep(0, 4'b0110, 1'b0, 1'b0);
      tick();

      // randomized gate tables on both instances
      repeat (6) begin
         sweep(0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
         sweep(1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      end
      tick();

      // SETTLE=0 instance, stuck-at-1, enough sweeps to saturate the counter
      for (int n = 0; n < 257; n++) sweep(1, 4'b1111, 1'b0, 1'b0);
      tick();
      chk_idle(1, "sat", 1'b0);
      chk_idle(0, "other", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
